// File: rtl/mips_rf_pkg.sv
// Shared types and default sizes for the MIPS register file.
// Used by mips_regfile and mips_rf_clear_fsm.
package mips_rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/mips_rf_clear_fsm.sv
// Sequential clear engine for the register file.
// Owns the state, the clear pointer, the busy flag and the dropped-write pulse, and muxes clear writes with external writes.
module mips_rf_clear_fsm
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_wr_err,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [DATA_W-1:0] o_mem_wdata
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    rf_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              wr_err_reg, wr_err_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= RF_CLEAR;
            ptr_reg    <= '0;
            wr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            wr_err_reg <= wr_err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        wr_err_next = i_we && (state_reg == RF_CLEAR);
        o_mem_we    = 1'b0;
        o_mem_waddr = i_waddr;
        o_mem_wdata = i_wdata;
        case (state_reg)
            RF_CLEAR: begin
                // External writes are dropped here; i_clr is ignored so the clear never restarts.
                o_mem_we    = 1'b1;
                o_mem_waddr = ptr_reg;
                o_mem_wdata = '0;
                ptr_next    = ptr_reg + ADDR_W'(1);
                if (ptr_reg == PTR_LAST) begin
                    state_next = RF_IDLE;
                end
            end
            RF_IDLE: begin
                o_mem_we = i_we && !((ZERO_REG != 0) && (i_waddr == '0));
                if (i_clr) begin
                    state_next = RF_CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = RF_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign o_busy   = (state_reg == RF_CLEAR);
    assign o_wr_err = wr_err_reg;

endmodule

// File: rtl/mips_regfile.sv
// 2-read/1-write MIPS register file with built-in zero-clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining MIPS_REGFILE_BYPASS_EN.
module mips_regfile
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_we,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    mips_rf_clear_fsm #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_clear_fsm (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (i_clr),
        .i_we        (i_we),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_wr_err    (o_wr_err),
        .o_mem_we    (mem_we),
        .o_mem_waddr (mem_waddr),
        .o_mem_wdata (mem_wdata)
    );

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign raddr[0] = i_raddr1;
    assign raddr[1] = i_raddr2;

    // Both ports share one priority chain: busy, hardwired zero, forward, stored entry.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic zero_hit;
            logic fwd_hit;
            assign zero_hit = (ZERO_REG != 0) && (raddr[gi] == '0);
`ifdef MIPS_REGFILE_BYPASS_EN
            assign fwd_hit = i_we && (raddr[gi] == i_waddr);
`else
            assign fwd_hit = 1'b0;
`endif
            assign rdata[gi] = o_busy   ? '0 :
                               zero_hit ? '0 :
                               fwd_hit  ? i_wdata :
                                          mem[raddr[gi]];
        end
    endgenerate

    assign o_rdata1 = rdata[0];
    assign o_rdata2 = rdata[1];

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench: two instances (hardwired r0 and ordinary r0) share stimulus
// and are compared against an array-based reference model, plus directed vectors.
module tb_mips_regfile;

`ifdef MIPS_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raddr1 = '0, raddr2 = '0, waddr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0, clr = 1'b0;
    logic [31:0] rd1_z1, rd2_z1, rd1_z0, rd2_z0;
    logic        busy_z1, err_z1, busy_z0, err_z0;

    always #5 clk = ~clk;

    mips_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_z1 (
        .i_clk(clk), .i_rst(rst), .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_rdata1(rd1_z1), .o_rdata2(rd2_z1), .i_waddr(waddr), .i_wdata(wdata),
        .i_we(we), .i_clr(clr), .o_busy(busy_z1), .o_wr_err(err_z1)
    );

    mips_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_z0 (
        .i_clk(clk), .i_rst(rst), .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_rdata1(rd1_z0), .o_rdata2(rd2_z0), .i_waddr(waddr), .i_wdata(wdata),
        .i_we(we), .i_clr(clr), .o_busy(busy_z0), .o_wr_err(err_z0)
    );

    // Reference model: register contents per instance, remaining busy cycles, expected error pulse.
    logic [31:0] m_z1 [32];
    logic [31:0] m_z0 [32];
    int          busy_cnt = 0;
    bit          err_m = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
        if (busy_cnt > 0) return 32'd0;
        if (zr && a == 5'd0) return 32'd0;
        if (BYP && we && a == waddr) return wdata;
        return zr ? m_z1[a] : m_z0[a];
    endfunction

    task automatic zero_model();
        for (int i = 0; i < 32; i++) begin
            m_z1[i] = '0;
            m_z0[i] = '0;
        end
    endtask

    // Advance model by one edge from the current inputs, then let the DUT take the same edge.
    task automatic tick();
        bit busy_now;
        busy_now = (busy_cnt > 0);
        if (rst) begin
            busy_cnt = 32;
            err_m    = 1'b0;
            zero_model();
        end else begin
            err_m = we && busy_now;
            if (busy_now) begin
                busy_cnt--;
            end else begin
                if (we) begin
                    if (waddr != 5'd0) m_z1[waddr] = wdata;
                    m_z0[waddr] = wdata;
                end
                if (clr) begin
                    busy_cnt = 32;
                    zero_model();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".busy_z1"}, 32'(busy_z1), 32'(busy_cnt > 0));
        chk({tag, ".busy_z0"}, 32'(busy_z0), 32'(busy_cnt > 0));
        chk({tag, ".err_z1"},  32'(err_z1),  32'(err_m));
        chk({tag, ".err_z0"},  32'(err_z0),  32'(err_m));
        chk({tag, ".rd1_z1"},  rd1_z1, exp_rd(1'b1, raddr1));
        chk({tag, ".rd2_z1"},  rd2_z1, exp_rd(1'b1, raddr2));
        chk({tag, ".rd1_z0"},  rd1_z0, exp_rd(1'b0, raddr1));
        chk({tag, ".rd2_z0"},  rd2_z0, exp_rd(1'b0, raddr2));
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;

        // Expected values for the hardwired-r0 instance, starting from an all-zero file.
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, BYP ? 32'hDEADBEEF : 32'd0, BYP ? 32'hDEADBEEF : 32'd0};
        vecs[1] = '{1'b1, 5'd0, 32'h00001234, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 32'd0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, BYP ? 32'hA5A5A5A5 : 32'd0, BYP ? 32'hA5A5A5A5 : 32'd0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 32'hA5A5A5A5, 32'd0};
        vecs[5] = '{1'b1, 5'd9, 32'h00000011, 5'd9, 5'd5, BYP ? 32'h11 : 32'd0, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 32'h11, 32'h11};

        // Reset then release: busy for exactly 32 cycles, reads zero throughout.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            check_all("rst_clear");
            chk("rst_busy_hi", 32'(busy_z1), 32'd1);
            chk("rst_rd_zero", rd1_z1, 32'd0);
            tick();
        end
        #1;
        chk("rst_busy_lo", 32'(busy_z1), 32'd0);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            #1;
            chk("post_rst_zero", rd1_z0, 32'd0);
        end

        // Table-driven vectors.
        for (int v = 0; v < 7; v++) begin
            we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            raddr1 = vecs[v].ra1; raddr2 = vecs[v].ra2;
            #1;
            chk($sformatf("vec%0d.rd1", v), rd1_z1, vecs[v].e1);
            chk($sformatf("vec%0d.rd2", v), rd2_z1, vecs[v].e2);
            chk($sformatf("vec%0d.err", v), 32'(err_z1), 32'd0);
            check_all($sformatf("vec%0d", v));
            tick();
        end
        we = 1'b0;

        // Fill r1..r31 with their index, clear, and attempt a write during the clear.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            check_all("fill");
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
        tick();
        we = 1'b0;
        #1;
        chk("clr_err_pulse", 32'(err_z1), 32'd1);
        tick();
        #1;
        chk("clr_err_clear", 32'(err_z1), 32'd0);
        n = 2;
        while (busy_z1 && n < 100) begin
            check_all("clr_busy");
            tick();
            n++;
        end
        chk("clr_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'd3;
            #1;
            chk("after_clr_zero", rd1_z1, 32'd0);
            chk("after_clr_r3", rd2_z0, 32'd0);
        end

        // Reset at clear cycle 10 restarts; an i_clr pulse mid-clear is ignored.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clr = (i == 5);
            tick();
        end
        clr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy_z1 && n < 100) begin
            clr = (n == 5);
            check_all("restart");
            tick();
            n++;
        end
        clr = 1'b0;
        chk("restart_len", 32'(n), 32'd32);

        // Register 0 behaves as ordinary storage only when not hardwired.
        we = 1'b1; waddr = 5'd0; wdata = 32'h77; raddr1 = 5'd1; raddr2 = 5'd1;
        check_all("r0_wr");
        tick();
        we = 1'b0; raddr1 = 5'd0;
        #1;
        chk("r0_plain", rd1_z0, 32'h77);
        chk("r0_hardwired", rd1_z1, 32'd0);
        chk("r0_no_err", 32'(err_z1), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            clr    = ($urandom_range(0, 49) == 0);
            rst    = ($urandom_range(0, 199) == 0);
            check_all("rand");
            tick();
        end
        rst = 1'b0; clr = 1'b0; we = 1'b0;
        check_all("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
